script_sequencer: RTL and testbench

- Parametrised successor to the level script timer; runs entirely in the 100 MHz `clk` domain, advanced by a one-cycle `tick` strobe instead of a derived clock.
- Measures scene duration (cutscene or in-game, length scaled by level) and raises `script_ended`.
- Drives NUM_CH independent periodic spawn channels, each presenting queued spawn requests to the event core over a valid/ready handshake.
- Sits between the top-level scene FSM and the event core.

---
 rtl/script_sequencer_pkg.sv | 17 +
 rtl/script_sequencer_spawn_channel.sv | 40 ++++
 rtl/script_sequencer.sv | 75 +++++++
 tb/tb_script_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/script_sequencer_pkg.sv
// script_sequencer_pkg: scene codes, field sizes and default timing for the script sequencer.
package script_sequencer_pkg;
   localparam int LEVEL_SIZE = 4;
   localparam int STATE_SIZE = 3;
   typedef enum logic [STATE_SIZE-1:0] {
      SCENE_BOOT   = 3'd0,
      SCENE_INTRO  = 3'd1,
      SCENE_BRIEF  = 3'd2,
      SCENE_INGAME = 3'd3,
      SCENE_OUTRO  = 3'd4
   } scene_e;
   localparam int DEF_INGAME_CODE    = 3;
   localparam int DEF_CUTSCENE_TICKS = 50;
   localparam int DEF_BASE_TICKS     = 300;
   localparam int DEF_STEP_TICKS     = 50;
   localparam int DEF_MAX_STEP       = 7;
endpackage

// File: rtl/script_sequencer_spawn_channel.sv
// spawn_channel: periodic request generator with saturating pending count and valid/ready handshake.
module spawn_channel import script_sequencer_pkg::*; #(
   parameter int PERIOD_W = 8,
   parameter int PEND_W   = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                tick,
   input  logic                armed,
   input  logic                hold,
   input  logic [PERIOD_W-1:0] period,
   input  logic                ready,
   output logic                valid,
   output logic                overflow
);
   logic [PERIOD_W-1:0] phase;
   logic [PEND_W-1:0]   pending;
   logic                step, req, accept;
   assign step   = tick && armed && (period != '0);
   assign req    = step && (phase == period - 1'b1);
   assign valid  = (pending != '0) && !hold;
   assign accept = valid && ready;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         phase    <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         phase   <= '0;
         pending <= '0;
      end else begin
         // a phase left beyond a shortened period wraps without emitting
         if (step) phase <= (phase >= period - 1'b1) ? '0 : phase + 1'b1;
         if (req && !accept) begin
            pending  <= (&pending) ? pending : pending + 1'b1;
            overflow <= overflow | (&pending);
         end else if (accept && !req) pending <= pending - 1'b1;
      end
endmodule

// File: rtl/script_sequencer.sv
// script_sequencer: tick-driven scene timer plus NUM_CH periodic spawn channels.
// Optional SCRIPT_SEQUENCER_PAUSE_EN adds a pause input that freezes ticks and masks spawn_valid.
module script_sequencer import script_sequencer_pkg::*; #(
   parameter int TIMER_W        = 10,
   parameter int LEVEL_W        = LEVEL_SIZE,
   parameter int STATE_W        = STATE_SIZE,
   parameter int INGAME_CODE    = DEF_INGAME_CODE,
   parameter int NUM_CH         = 2,
   parameter int PERIOD_W       = 8,
   parameter int PEND_W         = 3,
   parameter int CUTSCENE_TICKS = DEF_CUTSCENE_TICKS,
   parameter int BASE_TICKS     = DEF_BASE_TICKS,
   parameter int STEP_TICKS     = DEF_STEP_TICKS,
   parameter int MAX_STEP       = DEF_MAX_STEP
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       en,
`ifdef SCRIPT_SEQUENCER_PAUSE_EN
   input  logic                       pause,
`endif
   input  logic [STATE_W-1:0]         cur_state,
   input  logic [LEVEL_W-1:0]         cur_level,
   input  logic [NUM_CH*PERIOD_W-1:0] spawn_period,
   output logic [NUM_CH-1:0]          spawn_valid,
   input  logic [NUM_CH-1:0]          spawn_ready,
   output logic                       script_ended,
   output logic [TIMER_W-1:0]         timer_count,
   output logic [NUM_CH-1:0]          overflow
);
   logic [TIMER_W-1:0] timer, timer_end;
   logic [TIMER_W:0]   end_raw;
   logic [STATE_W-1:0] prev_state;
   logic [LEVEL_W-1:0] pair, step;
   logic               paused, tick_eff, scene_chg, ingame, armed;
`ifdef SCRIPT_SEQUENCER_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif
   assign tick_eff  = tick && !paused;
   assign scene_chg = cur_state != prev_state;
   assign ingame    = cur_state == STATE_W'(INGAME_CODE);
   assign pair      = cur_level >> 1;
   assign step      = (pair > LEVEL_W'(MAX_STEP)) ? LEVEL_W'(MAX_STEP) : pair;
   assign end_raw   = ingame ? (TIMER_W+1)'(BASE_TICKS) + (TIMER_W+1)'(STEP_TICKS) * (TIMER_W+1)'(step)
                             : (TIMER_W+1)'(CUTSCENE_TICKS);
   assign timer_end    = end_raw[TIMER_W] ? '1 : end_raw[TIMER_W-1:0];
   assign script_ended = timer == timer_end;
   assign timer_count  = timer;
   assign armed        = ingame && en && !script_ended;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         timer      <= '0;
         prev_state <= '0;
      end else if (scene_chg) begin
         timer      <= '0;
         prev_state <= cur_state;
      end else if (tick_eff && !script_ended) timer <= en ? timer + 1'b1 : '0;
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      spawn_channel #(.PERIOD_W(PERIOD_W), .PEND_W(PEND_W)) u_ch (
         .clk      (clk),
         .rst      (rst),
         .clr      (scene_chg),
         .tick     (tick_eff),
         .armed    (armed),
         .hold     (paused),
         .period   (spawn_period[c*PERIOD_W +: PERIOD_W]),
         .ready    (spawn_ready[c]),
         .valid    (spawn_valid[c]),
         .overflow (overflow[c])
      );
   end
endmodule

// File: tb/tb_script_sequencer.sv
// tb_script_sequencer: directed table and corner-case sequences for script_sequencer.
`timescale 1ns/1ps
module tb_script_sequencer;
   logic        clk = 0, rst = 1, tick = 0, en = 1;
   logic [2:0]  cur_state = 0;
   logic [3:0]  cur_level = 0;
   logic [15:0] spawn_period = 0;
   logic [1:0]  spawn_ready = 0, spawn_valid, overflow;
   logic        script_ended;
   logic [9:0]  timer_count;
`ifdef SCRIPT_SEQUENCER_PAUSE_EN
   logic        pause = 0;
`endif
   int checks = 0, errors = 0;

   script_sequencer dut (
      .clk(clk), .rst(rst), .tick(tick), .en(en),
`ifdef SCRIPT_SEQUENCER_PAUSE_EN
      .pause(pause),
`endif
      .cur_state(cur_state), .cur_level(cur_level), .spawn_period(spawn_period),
      .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .script_ended(script_ended),
      .timer_count(timer_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct { logic [2:0] state; logic [3:0] level; int end_ticks; } vec_t;
   vec_t tbl[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_tick();
      @(negedge clk) tick = 1;
      @(negedge clk) tick = 0;
   endtask

   task automatic new_scene(input logic [2:0] s);
      @(negedge clk) cur_state = 0;
      @(negedge clk) cur_state = s;
      @(negedge clk);
   endtask

   task automatic drain(output int n);
      n = 0;
      spawn_ready[0] = 1;
      for (int i = 0; i < 20; i++) begin
         if (spawn_valid[0]) n++;
         @(negedge clk);
      end
      spawn_ready[0] = 0;
   endtask

   initial begin
      int n, any1;
      tbl[0] = '{3'd1, 4'd0, 50};
      tbl[1] = '{3'd2, 4'd9, 50};
      tbl[2] = '{3'd3, 4'd0, 300};
      tbl[3] = '{3'd3, 4'd1, 300};
      tbl[4] = '{3'd3, 4'd5, 400};
      tbl[5] = '{3'd3, 4'd8, 500};
      tbl[6] = '{3'd3, 4'd15, 650};
      #12;
      chk("rst_timer", int'(timer_count), 0);
      chk("rst_valid", int'(spawn_valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_ended", int'(script_ended), 0);
      @(negedge clk) rst = 0;

      foreach (tbl[i]) begin
         new_scene(tbl[i].state);
         cur_level = tbl[i].level;
         for (int k = 1; k < tbl[i].end_ticks; k++) do_tick();
         chk("tbl_pre_timer", int'(timer_count), tbl[i].end_ticks - 1);
         chk("tbl_pre_ended", int'(script_ended), 0);
         do_tick();
         chk("tbl_end_timer", int'(timer_count), tbl[i].end_ticks);
         chk("tbl_end_ended", int'(script_ended), 1);
         do_tick();
         chk("tbl_hold_timer", int'(timer_count), tbl[i].end_ticks);
      end

      cur_level = 0;
      spawn_period = {8'd0, 8'd4};
      spawn_ready = 2'b11;
      any1 = 0;
      new_scene(3);
      for (int k = 1; k <= 12; k++) begin
         do_tick();
         any1 |= int'(spawn_valid[1]);
         chk("p4_valid", int'(spawn_valid[0]), int'(k % 4 == 0));
         if (k % 4 == 0) begin
            @(negedge clk);
            chk("p4_one_cycle", int'(spawn_valid[0]), 0);
         end
      end
      chk("ch1_disabled", any1, 0);

      spawn_ready = 0;
      spawn_period = {8'd0, 8'd1};
      new_scene(3);
      for (int k = 0; k < 7; k++) do_tick();
      chk("sat_valid", int'(spawn_valid[0]), 1);
      chk("sat_no_ovf", int'(overflow[0]), 0);
      do_tick();
      chk("sat_ovf", int'(overflow[0]), 1);
      drain(n);
      chk("sat_drain", n, 7);
      new_scene(3);
      chk("ovf_sticky", int'(overflow[0]), 1);

      do_tick();
      do_tick();
      spawn_ready[0] = 1;
      tick = 1;
      @(negedge clk);
      tick = 0;
      spawn_ready[0] = 0;
      drain(n);
      chk("req_and_accept", n, 2);

      for (int k = 0; k < 3; k++) do_tick();
      chk("pre_chg_valid", int'(spawn_valid[0]), 1);
      cur_state = 1;
      @(negedge clk);
      chk("chg_valid", int'(spawn_valid[0]), 0);
      chk("chg_timer", int'(timer_count), 0);

      spawn_ready = 2'b01;
      spawn_period = {8'd0, 8'd8};
      new_scene(3);
      for (int k = 0; k < 5; k++) do_tick();
      spawn_period = {8'd0, 8'd4};
      do_tick();
      chk("shrink_wrap_no_req", int'(spawn_valid[0]), 0);
      for (int k = 0; k < 3; k++) do_tick();
      chk("shrink_pre", int'(spawn_valid[0]), 0);
      do_tick();
      chk("shrink_req", int'(spawn_valid[0]), 1);

      spawn_period = 0;
      new_scene(1);
      for (int k = 0; k < 10; k++) do_tick();
      chk("en_timer", int'(timer_count), 10);
      en = 0;
      do_tick();
      chk("en_off_timer", int'(timer_count), 0);
      en = 1;

      spawn_ready = 0;
      spawn_period = {8'd0, 8'd1};
      new_scene(3);
      for (int k = 0; k < 9; k++) do_tick();
      chk("pre_rst_ovf", int'(overflow[0]), 1);
      @(posedge clk);
      #2 rst = 1;
      #1;
      chk("arst_timer", int'(timer_count), 0);
      chk("arst_valid", int'(spawn_valid), 0);
      chk("arst_ovf", int'(overflow), 0);
      chk("arst_ended", int'(script_ended), 0);
      #1 rst = 0;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
